// File: rtl/fn_sw_pipe.sv
// fn_sw_pipe: two-stage valid/ready pipeline applying AND/XOR/OR/accumulating-XOR
// to two WIDTH-bit operands, with a wrapping delivered-result counter.
module fn_sw_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       sel,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [1:0]       y_op,
    output logic [CNT_W-1:0] res_cnt
);
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [1:0]       sel_q, sel_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [1:0]       y_op_q, y_op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s2_load, accept, xfer;
    logic [WIDTH-1:0] acc_base, acc_next, f;

    assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
    assign in_ready = !s1_valid_q || s2_load;
    assign accept   = in_valid && in_ready;
    assign xfer     = s2_valid_q && out_ready;

    // clr zeroes the accumulator before a coincident ACC beat folds in
    assign acc_base = clr ? '0 : acc_q;
    assign acc_next = acc_base ^ (a_q ^ b_q);
    assign f = sel_q == 2'd0 ? (a_q & b_q) :
               sel_q == 2'd1 ? (a_q ^ b_q) :
               sel_q == 2'd2 ? (a_q | b_q) : acc_next;

    always_comb begin
        s1_valid_d = accept ? 1'b1 : (s2_load ? 1'b0 : s1_valid_q);
        a_d        = accept ? a : a_q;
        b_d        = accept ? b : b_q;
        sel_d      = accept ? sel : sel_q;
        s2_valid_d = s2_load ? 1'b1 : (xfer ? 1'b0 : s2_valid_q);
        y_d        = s2_load ? f : y_q;
        y_op_d     = s2_load ? sel_q : y_op_q;
        acc_d      = (s2_load && sel_q == 2'd3) ? acc_next : acc_base;
        cnt_d      = clr ? '0 : cnt_q + CNT_W'(xfer);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            sel_q      <= '0;
            s2_valid_q <= 1'b0;
            y_q        <= '0;
            y_op_q     <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sel_q      <= sel_d;
            s2_valid_q <= s2_valid_d;
            y_q        <= y_d;
            y_op_q     <= y_op_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign y         = y_q;
    assign y_op      = y_op_q;
    assign res_cnt   = cnt_q;
endmodule
